// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the BRAM arbiter: FSM state encoding and byte-lane enables.
// Pure declarations; no latency or backpressure of its own.
package mem_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CPU_RD,
        CPU_HOLD,
        SPI_RD,
        SPI_WR
    } state_t;

    localparam logic [1:0] BE_UPPER = 2'b10;
    localparam logic [1:0] BE_LOWER = 2'b01;

    // Big-endian byte addressing: even byte lives in D15:8.
    function automatic logic [1:0] spi_be(input logic odd);
        return odd ? BE_LOWER : BE_UPPER;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_spi_req_latch.sv
// One-deep SPI request holding register with sticky overflow; a new pulse is
// visible the same clock (bypass), a pulse onto an unconsumed request replaces it.
module spi_req_latch #(
    parameter int ADDR_BITS = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd,
    input  logic                 wr,
    input  logic [ADDR_BITS:0]   addr,
    input  logic [7:0]           di,
    input  logic                 start,
    output logic                 vld,
    output logic                 req_wr,
    output logic [ADDR_BITS:0]   req_addr,
    output logic [7:0]           req_di,
    output logic                 ovf
);

    logic                 pend;
    logic                 pulse;
    logic                 p_wr;
    logic [ADDR_BITS:0]   p_addr;
    logic [7:0]           p_di;

    // A held request is older than an incoming pulse, so it is served first.
    always_comb begin
        pulse    = rd || wr;
        vld      = pend || pulse;
        req_wr   = pend ? p_wr   : wr;
        req_addr = pend ? p_addr : addr;
        req_di   = pend ? p_di   : di;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend   <= 1'b0;
            ovf    <= 1'b0;
            p_wr   <= 1'b0;
            p_addr <= '0;
            p_di   <= '0;
        end else begin
            if (pulse) begin
                p_wr   <= wr;
                p_addr <= addr;
                p_di   <= di;
            end
            pend <= pulse ? (pend || !start) : (pend && !start);
            if (pulse && pend && !start)
                ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares a single-port BRAM between the 68k bus and the SPI loader; CPU reads take
// RD_LATENCY+1 clocks to DTACK, writes 1; SPI stalls the CPU by at most one access.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_BITS  = 15,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_as_n,
    input  logic                 cpu_rw,
    input  logic                 cpu_uds_n,
    input  logic                 cpu_lds_n,
    input  logic                 cpu_sel,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [15:0]          cpu_dout,
    output logic [15:0]          cpu_din,
    output logic                 cpu_dtack_n,
    input  logic                 spi_rd,
    input  logic                 spi_wr,
    input  logic [ADDR_BITS:0]   spi_addr,
    input  logic [7:0]           spi_di,
    output logic [7:0]           spi_do,
    output logic                 spi_ack,
    output logic                 spi_ovf,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [15:0]          mem_din,
    output logic                 mem_we,
    output logic [1:0]           mem_be,
    input  logic [15:0]          mem_dout
);

    localparam logic [1:0] LAT = 2'(RD_LATENCY);

    state_t               state;
    logic [1:0]           cnt;
    logic                 served;
    logic                 ret_hold;
    logic                 abort;
    logic                 cur_lo;

    logic                 req_vld;
    logic                 req_wr;
    logic [ADDR_BITS:0]   req_addr;
    logic [7:0]           req_di;

    logic                 cpu_req;
    logic                 cnt_done;
    logic                 spi_done;
    logic                 back_hold;
    logic                 free;
    logic                 hold_free;
    logic                 start;

    spi_req_latch #(.ADDR_BITS(ADDR_BITS)) u_req (
        .clk      (clk),
        .reset    (reset),
        .rd       (spi_rd),
        .wr       (spi_wr),
        .addr     (spi_addr),
        .di       (spi_di),
        .start    (start),
        .vld      (req_vld),
        .req_wr   (req_wr),
        .req_addr (req_addr),
        .req_di   (req_di),
        .ovf      (spi_ovf)
    );

    // free: memory idle with no CPU cycle parked; hold_free: memory idle while the
    // CPU sits in its DTACK phase. An SPI completion dispatches the next access
    // directly so a queued CPU read loses only one SPI access worth of clocks.
    always_comb begin
        cpu_req   = cpu_sel && !cpu_as_n && (!cpu_uds_n || !cpu_lds_n) && !served;
        cnt_done  = (cnt == LAT);
        spi_done  = (state == SPI_WR) || (state == SPI_RD && cnt_done);
        back_hold = ret_hold && !cpu_as_n;
        free      = (state == IDLE) || (spi_done && !back_hold);
        hold_free = (state == CPU_HOLD && !cpu_as_n) || (spi_done && back_hold);
        start     = req_vld && (free || hold_free);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            served      <= 1'b0;
            ret_hold    <= 1'b0;
            abort       <= 1'b0;
            cur_lo      <= 1'b0;
            cpu_din     <= '0;
            cpu_dtack_n <= 1'b1;
            spi_do      <= '0;
            spi_ack     <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            mem_we      <= 1'b0;
            mem_be      <= '0;
        end else begin
            mem_we  <= 1'b0;
            spi_ack <= 1'b0;
            if (cpu_as_n)
                served <= 1'b0;
            if (state == CPU_HOLD && !cpu_as_n) begin
                cpu_dtack_n <= 1'b0;
                served      <= 1'b1;
            end
            if (spi_done) begin
                spi_ack <= 1'b1;
                if (state == SPI_RD)
                    spi_do <= cur_lo ? mem_dout[7:0] : mem_dout[15:8];
                if (ret_hold && cpu_as_n)
                    cpu_dtack_n <= 1'b1;
            end

            if (start) begin
                ret_hold <= hold_free;
                cur_lo   <= req_addr[0];
                cnt      <= '0;
                mem_addr <= req_addr[ADDR_BITS:1];
                mem_be   <= spi_be(req_addr[0]);
                if (req_wr) begin
                    mem_we  <= 1'b1;
                    mem_din <= {req_di, req_di};
                    state   <= SPI_WR;
                end else begin
                    state   <= SPI_RD;
                end
            end else if (free) begin
                ret_hold <= 1'b0;
                if (cpu_req) begin
                    mem_addr <= cpu_addr;
                    mem_be   <= {!cpu_uds_n, !cpu_lds_n};
                    cnt      <= '0;
                    abort    <= 1'b0;
                    if (cpu_rw) begin
                        state <= CPU_RD;
                    end else begin
                        mem_we  <= 1'b1;
                        mem_din <= cpu_dout;
                        state   <= CPU_HOLD;
                    end
                end else begin
                    state <= IDLE;
                end
            end else if (hold_free) begin
                state <= CPU_HOLD;
            end else begin
                case (state)
                    CPU_RD: begin
                        if (cnt_done) begin
                            cpu_din <= mem_dout;
                            if (abort || cpu_as_n) begin
                                state <= IDLE;
                            end else begin
                                cpu_dtack_n <= 1'b0;
                                served      <= 1'b1;
                                state       <= CPU_HOLD;
                            end
                        end else begin
                            cnt <= cnt + 2'd1;
                            if (cpu_as_n)
                                abort <= 1'b1;
                        end
                    end
                    CPU_HOLD: begin
                        cpu_dtack_n <= 1'b1;
                        state       <= IDLE;
                    end
                    SPI_RD:  cnt   <= cnt + 2'd1;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
